// File: rtl/async_fifo_rd_stream.sv
// async_fifo_rd_stream
//   Read-side drain controller for the async FIFO (read clock domain).
//   Pops words whenever the FIFO is non-empty and there is credit, absorbs the
//   RAM read latency in a small circular output buffer, and presents the words
//   as a valid/ready stream that sustains one word per clock under continuous
//   ready.
// Ports
//   clk, reset    read-domain clock; synchronous active-high reset
//   fifo_empty    registered empty flag from the read-side pointer calc
//   fifo_pop      pop request (advances the FIFO read pointer this cycle)
//   fifo_rd_data  RAM read data, valid RD_LATENCY cycles after fifo_pop
//   flush         drop buffered and in-flight words; no pop this cycle
//   out_valid     out_data holds a word
//   out_ready     sink accepts; a transfer happens on out_valid & out_ready
//   out_data      head word of the output buffer
//   occupancy     words held in the buffer (in-flight words excluded)
//   overflow_err  sticky: a returning word found the buffer full
module async_fifo_rd_stream #(
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           fifo_empty,
  output logic                           fifo_pop,
  input  logic [DATA_W-1:0]              fifo_rd_data,
  input  logic                           flush,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy,
  output logic                           overflow_err
);

  localparam int OCC_W  = $clog2(BUF_DEPTH + 1);
  localparam int PEND_W = $clog2(BUF_DEPTH + RD_LATENCY + 1);
  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
    $error("async_fifo_rd_stream: RD_LATENCY must be in 1..3");
  end
  if (BUF_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
    $error("async_fifo_rd_stream: BUF_DEPTH must be >= RD_LATENCY+1");
  end

  logic [RD_LATENCY-1:0] infl;
  logic [DATA_W-1:0]     mem [BUF_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PEND_W-1:0]     infl_cnt;
  logic [PEND_W-1:0]     pend;
  logic                  fire_out;
  logic                  land;
  logic                  accept;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid = (occupancy != '0);
  assign out_data  = mem[rd_ptr];
  assign fire_out  = out_valid & out_ready;
  assign land      = infl[RD_LATENCY-1];
  // A word landing in a full buffer is only safe if the head leaves this cycle.
  assign accept    = land & ((occupancy != OCC_W'(BUF_DEPTH)) | fire_out);

  // Credit counts buffered plus in-flight words, so every popped word
  // is guaranteed a slot by the time it lands.
  always_comb begin
    infl_cnt = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      infl_cnt = infl_cnt + PEND_W'(infl[i]);
    end
    pend = PEND_W'(occupancy) + infl_cnt;
  end

  assign fifo_pop = ~reset & ~flush & ~fifo_empty &
                    ((pend - PEND_W'(fire_out)) < PEND_W'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      infl         <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      occupancy    <= '0;
      overflow_err <= 1'b0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      infl      <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      infl[0] <= fifo_pop;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        infl[i] <= infl[i-1];
      end

      if (fire_out) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end

      if (accept) begin
        mem[wr_ptr] <= fifo_rd_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end else if (land) begin
        overflow_err <= 1'b1;
      end

      case ({accept, fire_out})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
